// File: rtl/nn_pkg.sv
// nn_pkg: shared neuron word type, MAC state encoding and the saturating clip used by layer blocks
package nn_pkg;
  localparam int NN_W = 16;
  typedef logic signed [NN_W-1:0] nn_word_t;
  typedef enum logic {ACCUM, OUT} mac_state_t;
  typedef struct packed {
    nn_word_t word;
    logic     sat;
  } clip_t;
  function automatic clip_t sat_clip(input logic signed [63:0] acc, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    clip_t r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r.sat = (acc > hi) || (acc < lo);
    r.word = nn_word_t'(acc > hi ? hi : acc < lo ? lo : acc);
    return r;
  endfunction
endpackage

// File: rtl/nn_mac_neuron.sv
// nn_mac_neuron: serial multiply-accumulate neuron; after N_INPUTS beats adds bias,
// saturates and holds a registered pre-activation until the downstream stage takes it.
module nn_mac_neuron
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int W        = 16,
  parameter int ACC_W    = 40,
  parameter int FRAC     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] w_in,
  input  logic signed [W-1:0] bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] h_out,
  output logic                sat
);
  localparam int CNT_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  if (N_INPUTS < 1 || ACC_W < 2 * W + $clog2(N_INPUTS) + 1 || ACC_W > 64 || W > NN_W) begin : g_bad_params
    $error("nn_mac_neuron: illegal parameter combination");
  end
  mac_state_t                r_state;
  mac_state_t                w_next;
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [W-1:0]       r_h;
  logic                      r_sat;
  logic signed [2*W-1:0]     w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [63:0]        w_sum64;
  logic                      w_fire;
  logic                      w_last;
  clip_t                     w_clip;
  always_comb begin
    w_fire = in_valid && r_state == ACCUM;
    w_last = r_cnt == CNT_W'(N_INPUTS - 1);
    w_prod = ((2 * W)'(x_in) * (2 * W)'(w_in)) >>> FRAC;
    w_prod_ext = ACC_W'(w_prod);
    w_bias_ext = w_last ? ACC_W'(bias) : ACC_W'(0);
    w_sum = r_acc + w_prod_ext + w_bias_ext;
    w_sum64 = 64'(w_sum);
    w_clip = sat_clip(w_sum64, W);
    w_next = r_state == ACCUM ? (w_fire && w_last ? OUT : ACCUM) : (out_ready ? ACCUM : OUT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_h     <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_acc <= w_last ? '0 : w_sum;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_h   <= w_clip.word[W-1:0];
          r_sat <= w_clip.sat;
        end
      end
    end
  end
  assign in_ready  = r_state == ACCUM;
  assign out_valid = r_state == OUT;
  assign h_out     = r_h;
  assign sat       = r_sat;
endmodule

// File: tb/tb_nn_mac_neuron.sv
// tb_nn_mac_neuron: directed and randomized checks of the MAC neuron against an arithmetic model,
// one 2-input integer instance and one 4-input FRAC=4 instance.
module tb_nn_mac_neuron;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
  logic signed [15:0] a_x, a_w, a_bias, a_h;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
  logic signed [15:0] b_x, b_w, b_bias, b_h;

  nn_mac_neuron #(.N_INPUTS(2), .W(16), .ACC_W(40), .FRAC(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x_in(a_x), .w_in(a_w), .bias(a_bias), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .h_out(a_h), .sat(a_sat));

  nn_mac_neuron #(.N_INPUTS(4), .W(16), .ACC_W(40), .FRAC(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_in(b_x), .w_in(b_w), .bias(b_bias), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .h_out(b_h), .sat(b_sat));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint prodf(input int x, input int w, input int frac);
    return (longint'(x) * longint'(w)) >>> frac;
  endfunction

  function automatic void ref_clip(input longint s, output longint h, output logic st);
    st = (s > 32767) || (s < -32768);
    h = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic run_a(input int x0, input int x1, input int w0, input int w1, input int b,
                       input int gap, input bit rdy, input string tag);
    longint eh;
    logic   es;
    ref_clip(prodf(x0, w0, 0) + prodf(x1, w1, 0) + longint'(b), eh, es);
    a_out_ready = rdy;
    a_in_valid = 1'b1; a_x = 16'(x0); a_w = 16'(w0); a_bias = 16'($urandom);
    @(posedge clk); #1;
    check({tag, ".mid_valid"}, a_out_valid, 0);
    a_in_valid = 1'b0; a_x = 16'($urandom); a_w = 16'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
      check({tag, ".gap_valid"}, a_out_valid, 0);
    end
    a_in_valid = 1'b1; a_x = 16'(x1); a_w = 16'(w1); a_bias = 16'(b);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check({tag, ".valid"}, a_out_valid, 1);
    check({tag, ".h"}, a_h, eh);
    check({tag, ".sat"}, a_sat, es);
    check({tag, ".busy"}, a_in_ready, 0);
    if (rdy) begin
      @(posedge clk); #1;
      check({tag, ".drop_valid"}, a_out_valid, 0);
      check({tag, ".ready_back"}, a_in_ready, 1);
    end
  endtask

  task automatic run_b(input int xs[4], input int ws[4], input int b, input string tag);
    longint s;
    longint eh;
    logic   es;
    s = longint'(b);
    for (int i = 0; i < 4; i++) s += prodf(xs[i], ws[i], 4);
    ref_clip(s, eh, es);
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_x = 16'(xs[i]); b_w = 16'(ws[i]);
      b_bias = i == 3 ? 16'(b) : 16'($urandom);
      @(posedge clk); #1;
      if (i < 3) check({tag, ".mid_valid"}, b_out_valid, 0);
    end
    b_in_valid = 1'b0;
    check({tag, ".valid"}, b_out_valid, 1);
    check({tag, ".h"}, b_h, eh);
    check({tag, ".sat"}, b_sat, es);
    @(posedge clk); #1;
    check({tag, ".drop_valid"}, b_out_valid, 0);
  endtask

  initial begin
    int xs[4];
    int ws[4];
    a_in_valid = 0; a_out_ready = 1; a_x = 0; a_w = 0; a_bias = 0;
    b_in_valid = 0; b_out_ready = 1; b_x = 0; b_w = 0; b_bias = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.valid", a_out_valid, 0);
    check("rst.ready", a_in_ready, 1);
    check("rst.h", a_h, 0);
    check("rst.sat", a_sat, 0);
    check("rst.b_ready", b_in_ready, 1);

    run_a(1, 1, 20, 20, -30, 0, 1, "and11");
    run_a(1, 0, 20, 20, -30, 0, 1, "and10");
    run_a(0, 1, 20, 20, -30, 0, 1, "and01");
    run_a(0, 0, 20, 20, -30, 0, 1, "and00");

    run_a(1, 1, 20, 20, -30, 0, 0, "bp");
    a_in_valid = 1'b1; a_x = 16'sd5; a_w = 16'sd5; a_bias = 16'sd100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", a_out_valid, 1);
      check("bp.hold_h", a_h, 10);
      check("bp.hold_sat", a_sat, 0);
      check("bp.hold_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_ready", a_in_ready, 1);
    check("bp.release_valid", a_out_valid, 0);
    run_a(0, 0, 20, 20, -30, 0, 1, "bp.after");

    run_a(1, 1, 20, 20, -30, 2, 1, "bubble");
    run_a(32767, 32767, 32767, 32767, 0, 0, 1, "sat_hi");
    run_a(-32768, -32768, 32767, 32767, 0, 0, 1, "sat_lo");

    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_x = 16'sd1; a_w = 16'sd20; a_bias = 16'sd0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid.valid_async", a_out_valid, 0);
    check("rstmid.ready_async", a_in_ready, 1);
    @(posedge clk); #1;
    check("rstmid.valid_held", a_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid.valid_after", a_out_valid, 0);
    run_a(1, 1, 20, 20, -30, 0, 1, "rstmid.vec");

    for (int k = 0; k < 12; k++)
      run_a(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(0, 2)), 1, "rand_a");

    xs = '{16, 16, 16, 16};
    ws = '{16, 16, 16, 16};
    run_b(xs, ws, 0, "frac4");
    xs = '{-1, 3, -7, 1};
    ws = '{1, 5, 3, 15};
    run_b(xs, ws, 0, "frac4_neg");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = rnd16();
        ws[i] = rnd16();
      end
      run_b(xs, ws, rnd16(), "rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
